// File: rtl/mac_wave_sequencer.sv
// Bit-serial weight-column sequencer for one Wave-style MAC lane.
// Optional build macro WAVE_ZERO_SKIP_EN: when defined, all-zero bit columns are skipped.
module mac_wave_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 16,
  parameter int unsigned COL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] weight [VEC_LENGTH],
  input  logic                  accum_init,
  output logic                  mac_en,
  output logic                  mac_load_accum,
  output logic [VEC_LENGTH-1:0] w_bit,
  output logic [VEC_LENGTH-1:0] sign,
  output logic [COL_WIDTH-1:0]  column_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned MAG_BITS = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [MAG_BITS-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0] wgt_q [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] wgt_d [VEC_LENGTH];
  logic [VEC_LENGTH-1:0] sign_q, sign_d;
  logic [VEC_LENGTH-1:0] wbit_q, wbit_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  ready_q, ready_d;
  logic                  en_q, en_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  emit;
  logic [MAG_BITS-1:0]   new_mask;
  logic [MAG_BITS-1:0]   m_cur;
  logic [COL_WIDTH-1:0]  csel;
  logic [DATA_WIDTH-1:0] src [VEC_LENGTH];

  // Outputs are registered, so the column issued in a given cycle is computed
  // from the state being left; a fresh vector's first column comes straight off
  // the weight inputs on the accept edge.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    wgt_d    = wgt_q;
    sign_d   = sign_q;
    en_d     = 1'b0;
    load_d   = 1'b0;
    wbit_d   = '0;
    col_d    = '0;
    done_d   = 1'b0;
    emit     = 1'b0;
    m_cur    = mask_q;
    src      = wgt_q;
    csel     = '0;
    accept   = w_valid && ready_q;

    new_mask = '0;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
      new_mask = new_mask | weight[i][MAG_BITS-1:0];
    end
`ifdef WAVE_ZERO_SKIP_EN
`else
    new_mask = '1;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wgt_d  = weight;
          mask_d = new_mask;
          for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
            sign_d[i] = weight[i][DATA_WIDTH-1];
          end
          if (accum_init) begin
            state_d = S_LOAD;
            load_d  = 1'b1;
          end else begin
            m_cur = new_mask;
            src   = weight;
            emit  = 1'b1;
          end
        end
      end
      S_LOAD:  emit = 1'b1;
      S_RUN:   emit = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      if (m_cur == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        for (int unsigned c = 0; c < MAG_BITS; c++) begin
          if (m_cur[c]) csel = COL_WIDTH'(c);
        end
        state_d = S_RUN;
        en_d    = 1'b1;
        col_d   = csel;
        for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
          wbit_d[i] = src[i][csel];
        end
        mask_d = m_cur & ~(MAG_BITS'(1) << csel);
      end
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      sign_q  <= '0;
      wbit_q  <= '0;
      col_q   <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sign_q  <= sign_d;
      wbit_q  <= wbit_d;
      col_q   <= col_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    wgt_q <= wgt_d;
  end

  assign w_ready        = ready_q;
  assign mac_en         = en_q;
  assign mac_load_accum = load_q;
  assign w_bit          = wbit_q;
  assign sign           = sign_q;
  assign column_idx     = col_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_mac_wave_sequencer.sv
// Scoreboard bench for mac_wave_sequencer: expected per-cycle events are queued by
// the stimulus and popped by a monitor on every busy cycle; a small MAC model checks results.
module tb_mac_wave_sequencer;
  localparam int VL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_valid;
  logic          w_ready;
  logic [7:0]    weight [VL];
  logic          accum_init;
  logic          mac_en;
  logic          mac_load_accum;
  logic [VL-1:0] w_bit;
  logic [VL-1:0] sign;
  logic [2:0]    column_idx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mac_wave_sequencer #(.DATA_WIDTH(8), .VEC_LENGTH(VL), .COL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
    .weight(weight), .accum_init(accum_init), .mac_en(mac_en),
    .mac_load_accum(mac_load_accum), .w_bit(w_bit), .sign(sign),
    .column_idx(column_idx), .busy(busy), .done(done)
  );

  typedef struct {
    bit            load;
    bit            en;
    logic [2:0]    col;
    logic [VL-1:0] wbit;
    logic [VL-1:0] sgn;
    bit            done;
  } ev_t;

  ev_t exp_q[$];
  int  mac_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_done_cyc = -100;
  int  acc = 0;
  int  act [VL];
  bit  started = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic ev_t mk(input bit ld, input bit en, input int col,
                             input logic [VL-1:0] wb, input logic [VL-1:0] sg, input bit dn);
    ev_t e;
    e.load = ld; e.en = en; e.col = 3'(col); e.wbit = wb; e.sgn = sg; e.done = dn;
    return e;
  endfunction

  function automatic int smval(input logic [7:0] w);
    return w[7] ? -int'(w[6:0]) : int'(w[6:0]);
  endfunction

  task automatic push_mac(input logic [7:0] w [VL], input bit ai);
    int s;
    s = ai ? 100 : 0;
    for (int i = 0; i < VL; i++) s += act[i] * smval(w[i]);
    mac_q.push_back(s);
  endtask

  task automatic push_model(input logic [7:0] w [VL], input bit ai);
    logic [6:0]    mask;
    logic [VL-1:0] sg;
    logic [VL-1:0] wb;
    mask = '0;
    for (int i = 0; i < VL; i++) begin
      mask = mask | w[i][6:0];
      sg[i] = w[i][7];
    end
`ifndef WAVE_ZERO_SKIP_EN
    mask = 7'h7f;
`endif
    if (ai) exp_q.push_back(mk(1, 0, 0, '0, sg, 0));
    for (int c = 6; c >= 0; c--) begin
      if (mask[c]) begin
        for (int i = 0; i < VL; i++) wb[i] = w[i][c];
        exp_q.push_back(mk(0, 1, c, wb, sg, 0));
      end
    end
    exp_q.push_back(mk(0, 0, 0, '0, sg, 1));
    push_mac(w, ai);
  endtask

  task automatic send(input logic [7:0] w [VL], input bit ai, input bit keep, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = -1;
    weight = w;
    accum_init = ai;
    w_valid = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (w_ready) begin
        acc_cyc = cyc;
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (started) begin
      if (busy) begin
        ev_t e;
        chk("ready_while_busy", w_ready, 0);
        if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("load", mac_load_accum, e.load);
          chk("en", mac_en, e.en);
          chk("col", column_idx, e.col);
          chk("wbit", w_bit, e.wbit);
          chk("sign", sign, e.sgn);
          chk("done", done, e.done);
        end
        if (mac_load_accum) acc = 100;
        if (mac_en)
          for (int i = 0; i < VL; i++)
            if (w_bit[i]) acc += (sign[i] ? -act[i] : act[i]) * (1 << column_idx);
        if (done) begin
          last_done_cyc = cyc;
          if (mac_q.size() == 0) chk("mac_unexpected", 1, 0);
          else chk("mac_result", 64'(acc), 64'(mac_q.pop_front()));
          acc = 0;
        end
      end else begin
        chk("idle_outputs", {mac_en, mac_load_accum, done, w_bit, column_idx}, '0);
      end
    end
    if (reset) acc = 0;
  end

  initial begin
    logic [7:0]    v [VL];
    logic [7:0]    v2 [VL];
    logic [VL-1:0] wb;
    int            ac1, ac2;

    reset = 1'b1;
    w_valid = 1'b0;
    accum_init = 1'b0;
    for (int i = 0; i < VL; i++) begin
      weight[i] = '0;
      act[i] = i + 1;
    end
    @(posedge clk);
    #1;
    started = 1;
    @(negedge clk);
    chk("reset_ready", w_ready, 0);
    chk("reset_outs", {busy, done, mac_en, mac_load_accum, w_bit, sign, column_idx}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", w_ready, 1);
    @(posedge clk);
    #1;

    // all-zero vector
    v = '{default: 8'h00};
`ifndef WAVE_ZERO_SKIP_EN
    for (int c = 6; c >= 0; c--) exp_q.push_back(mk(0, 1, c, '0, '0, 0));
`endif
    exp_q.push_back(mk(0, 0, 0, '0, '0, 1));
    push_mac(v, 0);
    send(v, 0, 0, ac1);
    wait_idle();

    // lane0 = +5
    v = '{default: 8'h00};
    v[0] = 8'h05;
`ifdef WAVE_ZERO_SKIP_EN
    exp_q.push_back(mk(0, 1, 2, 16'h0001, '0, 0));
    exp_q.push_back(mk(0, 1, 0, 16'h0001, '0, 0));
`else
    for (int c = 6; c >= 0; c--)
      exp_q.push_back(mk(0, 1, c, (c == 2 || c == 0) ? 16'h0001 : 16'h0000, '0, 0));
`endif
    exp_q.push_back(mk(0, 0, 0, '0, '0, 1));
    push_mac(v, 0);
    send(v, 0, 0, ac1);
    wait_idle();

    // lane3 = -127, lane7 = +64, with accumulator seed
    v = '{default: 8'h00};
    v[3] = 8'hFF;
    v[7] = 8'h40;
    exp_q.push_back(mk(1, 0, 0, '0, 16'h0008, 0));
    for (int c = 6; c >= 0; c--) begin
      wb = 16'h0008;
      if (c == 6) wb = 16'h0088;
      exp_q.push_back(mk(0, 1, c, wb, 16'h0008, 0));
    end
    exp_q.push_back(mk(0, 0, 0, '0, 16'h0008, 1));
    push_mac(v, 1);
    send(v, 1, 0, ac1);
    wait_idle();

    // back-to-back with w_valid held high
    v = '{default: 8'h00};
    v[0] = 8'h05;
    v[5] = 8'h83;
    v2 = '{default: 8'h00};
    v2[1] = 8'h30;
    v2[9] = 8'hC8;
    push_model(v, 0);
    push_model(v2, 1);
    send(v, 0, 1, ac1);
    send(v2, 1, 0, ac2);
    chk("b2b_accept_after_done", 64'(ac2), 64'(last_done_cyc + 1));
    wait_idle();

    // reset during the second RUN cycle of a 7-column vector
    v = '{default: 8'h00};
    v[3] = 8'hFF;
    exp_q.push_back(mk(0, 1, 6, 16'h0008, 16'h0008, 0));
    exp_q.push_back(mk(0, 1, 5, 16'h0008, 16'h0008, 0));
    send(v, 0, 0, ac1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_reset_outs", {w_ready, busy, done, mac_en, mac_load_accum, w_bit, sign, column_idx}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midrun_reset", w_ready, 1);
    chk("no_done_after_abort", done, 0);
    @(posedge clk);
    #1;

    // MAC integration with random weights and activations
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < VL; i++) begin
        v[i] = 8'($urandom_range(0, 255));
        act[i] = int'($urandom_range(0, 255)) - 128;
      end
      push_model(v, 1);
      send(v, 1, 0, ac1);
      wait_idle();
    end

    chk("exp_queue_empty", 64'(exp_q.size()), 0);
    chk("mac_queue_empty", 64'(mac_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
